ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

PS/2 keyboard receiver feeding the SAM Coupé core's keyboard matrix logic from the raw `clkps2`/`dataps2` pins. It synchronises and glitch-filters the PS/2 lines and deframes 11-bit device-to-host frames. It optionally folds E0/F0 prefixes into flags, then queues decoded codes in a small FIFO behind a valid/ack handshake.

## Interface
- `FILTER_LEN`, 8: consecutive equal samples required before filtered `clkps2` changes (range 2..255).
- `TIMEOUT_CYCLES`, 2400: idle `clk24` cycles between falling edges that abort a frame (100 µs at 24 MHz).
- `FIFO_DEPTH`, 4: output queue entries; power of two, minimum 2.
- `clk24`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clkps2`  in  1  raw PS/2 clock pin, asynchronous.
- `dataps2`  in  1  raw PS/2 data pin, asynchronous.
- `code`  out  8  scancode at FIFO head.
- `extended`  out  1  head entry was preceded by E0.
- `released`  out  1  head entry was preceded by F0.
- `valid`  out  1  FIFO non-empty; `code`/`extended`/`released` meaningful.
- `ack`  in  1  pops head when `valid`=1; ignored when `valid`=0.
- `frame_err`  out  1  one-cycle pulse on parity, stop or timeout error.
- `overflow`  out  1  one-cycle pulse when a decoded entry is dropped because the FIFO is full.

## Operation
- Both pins pass through 2-FF synchronisers. Synchronised clock feeds the filter counter; filtered clock `fclk` flips after `FILTER_LEN` consecutive opposite samples. Data is used synchronised but unfiltered.
- `fall` = `fclk_prev & ~fclk`; data is sampled only in cycles where `fall`=1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0, clear bit counter and go to DATA. Data=1 is ignored and no error is raised.
  - DATA: on `fall`, shift bit into MSB of an 8-bit right-shift register (LSB-first wire order). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, latch parity ok = XOR(byte, bit) == 1 (odd parity), then go to STOP.
  - STOP: on `fall`, if bit=1 and parity ok, strobe `byte_done`; otherwise pulse `frame_err`. Go to IDLE in either case.
- Timeout counter clears on every `fall` and while in IDLE. Outside IDLE, reaching `TIMEOUT_CYCLES-1` forces IDLE and pulses `frame_err`.
- Prefix stage on `byte_done`:
  - E0 sets `ext_pend`; F0 sets `rel_pend`; neither is queued.
  - Any other byte pushes `{ext_pend, rel_pend, byte}` and clears both pends.
  - `frame_err` clears both pends.
- FIFO entry is 10 bits. Push is accepted if not full or a pop occurs in the same cycle. Otherwise the entry is dropped and `overflow` pulses. Pop on `valid & ack`. Head outputs are registered FIFO storage, not a bypass.

## Timing
- Reset values: `code`=0, `extended`=0, `released`=0, `valid`=0, `frame_err`=0, `overflow`=0. Reset also clears FIFO pointers, FSM (IDLE), pends, and filter/timeout counters. `fclk`/`fclk_prev` reset to 1.
- Raw pin edge to `fall`: 2 + `FILTER_LEN` cycles.
- `fall` of stop bit (cycle N): `byte_done` registered at N+1, FIFO written at the end of N+1, `valid`=1 in cycle N+2.
- `frame_err` is asserted in cycle N+1 for STOP/parity failures and in the cycle after the timeout hit.
- `ack` in cycle M with `valid`=1: next entry, or `valid`=0, appears in cycle M+1.
- Simultaneous push and pop while full: both succeed, no `overflow`. Push and pop while empty: `valid` goes high next cycle, and the pop is ignored.
- `rst` mid-frame discards the partial frame and all queued entries.

## Configuration
- `PS2_PREFIX_DECODE_EN` defined: E0/F0 handling exactly as above.
- Undefined: every byte that passes deframing, including E0 and F0, is pushed with `extended`=`released`=0. Pend registers are not built.

## Structure
- Package `ps2_pkg`: FSM state enum, `PS2_PREFIX_EXT`=8'hE0, `PS2_PREFIX_REL`=8'hF0, `PS2_ENTRY_W`=10.
- Sub-module `ps2_rx_fifo`: parameterised synchronous FIFO (depth, width) with full/empty and simultaneous push/pop.

## Test plan
- Frame 0x1C, correct parity, 80 µs bit period → one entry: `code`=1C, flags 0, `valid` rises 2 cycles after the stop `fall`; `ack` → `valid`=0 next cycle.
- Sequence E0, F0, 0x75 (with macro) → single entry: 75, `extended`=1, `released`=1. Without macro → three entries: E0, F0, 75, flags 0.
- Frame 0x1C with bad parity → `frame_err` one-cycle pulse, no entry; the following good 0x1B is queued normally.
- Clock stops after 4 data bits for >`TIMEOUT_CYCLES` → `frame_err` pulse, FSM IDLE; the next full frame decodes correctly.
- Glitches of `FILTER_LEN-1` cycles on `clkps2` mid-frame → no extra bit shifted, byte correct.
- Five frames, no `ack` (depth 4) → 4 entries retained in order, `overflow` pulse on the 5th; `ack` in the same cycle as the 5th push → no overflow, 4 entries remain.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: deframer FSM states,
// scancode prefix bytes, queue entry width and the frame parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;
  localparam int         PS2_ENTRY_W    = 10;

  // PS/2 frames use odd parity: data byte plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
    return ^{data_byte, parity_bit};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small synchronous FIFO holding decoded key entries. A push into a full
// queue is still accepted when a pop happens in the same cycle. The head
// entry is read straight out of the storage registers.
module ps2_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign empty = (count_r == {CW{1'b0}});
  assign full  = (count_r == CW'(DEPTH));
  assign head  = mem_r[rd_ptr_r];

  // Pops only act on a non-empty queue; pushes need room or a concurrent pop.
  always_comb begin
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the PS/2 pins,
// deframes 11-bit device-to-host frames, optionally folds E0/F0 prefixes
// into flags, and queues entries behind a valid/ack handshake.
// Optional feature macro: PS2_PREFIX_DECODE_EN (prefix folding into flags).
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2400,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk24,
  input  logic       rst,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic [7:0] code,
  output logic       extended,
  output logic       released,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  logic              clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic              fclk_r, fclk_prev_r;
  logic [FILT_W-1:0] filt_cnt_r;
  logic              fall_s;
  logic [TO_W-1:0]   to_cnt_r;
  logic              timeout_hit_s;

  ps2_state_e        state_r, state_nx_s;
  logic [7:0]        shift_r, shift_nx_s;
  logic [2:0]        bit_cnt_r, bit_cnt_nx_s;
  logic              par_ok_r, par_ok_nx_s;
  logic [7:0]        byte_r, byte_nx_s;
  logic              byte_done_r, byte_done_nx_s;
  logic              frame_err_r, frame_err_nx_s;

  logic                   push_s;
  logic [PS2_ENTRY_W-1:0] entry_s;
  logic                   pop_s;
  logic                   drop_s;
  logic                   overflow_r;
  logic                   fifo_full_s, fifo_empty_s;
  logic [PS2_ENTRY_W-1:0] fifo_head_s;

  // Two-flop synchronisers for both asynchronous PS/2 pins (idle level is high).
  always_ff @(posedge clk24) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= clkps2;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= dataps2;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter: fclk follows the synced clock only after FILTER_LEN equal opposite samples.
  always_ff @(posedge clk24) begin
    if (rst) begin
      fclk_r      <= 1'b1;
      fclk_prev_r <= 1'b1;
      filt_cnt_r  <= {FILT_W{1'b0}};
    end else begin
      fclk_prev_r <= fclk_r;
      if (clk_sync_r == fclk_r) begin
        filt_cnt_r <= {FILT_W{1'b0}};
      end else if (filt_cnt_r == FILT_LAST) begin
        fclk_r     <= clk_sync_r;
        filt_cnt_r <= {FILT_W{1'b0}};
      end else begin
        filt_cnt_r <= filt_cnt_r + FILT_W'(1);
      end
    end
  end

  assign fall_s        = fclk_prev_r & ~fclk_r;
  assign timeout_hit_s = (state_r != ST_IDLE) && (to_cnt_r == TO_LAST);

  // Inter-edge timeout counter; runs only while a frame is in progress.
  always_ff @(posedge clk24) begin
    if (rst) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (fall_s || (state_r == ST_IDLE) || timeout_hit_s) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  // Deframer state and datapath registers.
  always_ff @(posedge clk24) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      par_ok_r    <= 1'b0;
      byte_r      <= 8'h00;
      byte_done_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      shift_r     <= shift_nx_s;
      bit_cnt_r   <= bit_cnt_nx_s;
      par_ok_r    <= par_ok_nx_s;
      byte_r      <= byte_nx_s;
      byte_done_r <= byte_done_nx_s;
      frame_err_r <= frame_err_nx_s;
    end
  end

  // Deframer next state: start bit, 8 data bits LSB first, odd parity, stop bit.
  always_comb begin
    state_nx_s     = state_r;
    shift_nx_s     = shift_r;
    bit_cnt_nx_s   = bit_cnt_r;
    par_ok_nx_s    = par_ok_r;
    byte_nx_s      = byte_r;
    byte_done_nx_s = 1'b0;
    frame_err_nx_s = 1'b0;
    if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!data_sync_r) begin
            bit_cnt_nx_s = 3'd0;
            state_nx_s   = ST_DATA;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_nx_s = {data_sync_r, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_nx_s = ST_PARITY;
          end else begin
            bit_cnt_nx_s = bit_cnt_r + 3'd1;
          end
        end
        ST_PARITY: begin
          par_ok_nx_s = odd_parity_ok(shift_r, data_sync_r);
          state_nx_s  = ST_STOP;
        end
        ST_STOP: begin
          if (data_sync_r && par_ok_r) begin
            byte_done_nx_s = 1'b1;
            byte_nx_s      = shift_r;
          end else begin
            frame_err_nx_s = 1'b1;
          end
          state_nx_s = ST_IDLE;
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end else if (timeout_hit_s) begin
      state_nx_s     = ST_IDLE;
      frame_err_nx_s = 1'b1;
    end else begin
      state_nx_s = state_r;
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_pend_r, rel_pend_r;
  logic is_prefix_s;

  // Prefix bytes are absorbed into flags; everything else is queued with them.
  always_comb begin
    is_prefix_s = (byte_r == PS2_PREFIX_EXT) || (byte_r == PS2_PREFIX_REL);
    push_s      = byte_done_r & ~is_prefix_s;
    entry_s     = {ext_pend_r, rel_pend_r, byte_r};
  end

  // Pending prefix flags: set by E0/F0, consumed by the next key, dropped on frame errors.
  always_ff @(posedge clk24) begin
    if (rst || frame_err_r) begin
      ext_pend_r <= 1'b0;
      rel_pend_r <= 1'b0;
    end else if (byte_done_r) begin
      if (byte_r == PS2_PREFIX_EXT) begin
        ext_pend_r <= 1'b1;
      end else if (byte_r == PS2_PREFIX_REL) begin
        rel_pend_r <= 1'b1;
      end else begin
        ext_pend_r <= 1'b0;
        rel_pend_r <= 1'b0;
      end
    end else begin
      ext_pend_r <= ext_pend_r;
      rel_pend_r <= rel_pend_r;
    end
  end
`else
  // Raw mode: every good byte is queued with both flags clear.
  always_comb begin
    push_s  = byte_done_r;
    entry_s = {2'b00, byte_r};
  end
`endif

  assign pop_s  = ack & ~fifo_empty_s;
  assign drop_s = push_s & fifo_full_s & ~pop_s;

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_ENTRY_W)
  ) u_fifo (
    .clk       (clk24),
    .rst       (rst),
    .push      (push_s),
    .push_data (entry_s),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s)
  );

  // One-cycle overflow pulse for an entry dropped at a full queue.
  always_ff @(posedge clk24) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= drop_s;
    end
  end

  assign code      = fifo_head_s[7:0];
  assign released  = fifo_head_s[8];
  assign extended  = fifo_head_s[9];
  assign valid     = ~fifo_empty_s;
  assign frame_err = frame_err_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed self-checking bench for ps2_keyboard_rx. Works with and without
// PS2_PREFIX_DECODE_EN defined.
module tb_ps2_keyboard_rx;

  localparam int F    = 8;
  localparam int TO   = 2400;
  localparam int HALF = 24;

  logic       clk24   = 1'b0;
  logic       rst     = 1'b1;
  logic       clkps2  = 1'b1;
  logic       dataps2 = 1'b1;
  logic       ack     = 1'b0;
  logic [7:0] code;
  logic       extended, released, valid, frame_err, overflow;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int ovf_cnt  = 0;

  ps2_keyboard_rx #(
    .FILTER_LEN     (F),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk24     (clk24),
    .rst       (rst),
    .clkps2    (clkps2),
    .dataps2   (dataps2),
    .code      (code),
    .extended  (extended),
    .released  (released),
    .valid     (valid),
    .ack       (ack),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk24 = ~clk24;

  // Count high cycles of the error/overflow pulses.
  always @(negedge clk24) begin
    if (frame_err === 1'b1) err_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    dataps2 = b;
    repeat (HALF) @(posedge clk24);
    #1 clkps2 = 1'b0;
    repeat (HALF) @(posedge clk24);
    #1 clkps2 = 1'b1;
  endtask

  task automatic send_bit_glitch(input logic b);
    dataps2 = b;
    repeat (12) @(posedge clk24);
    #1 clkps2 = 1'b0;
    repeat (F - 1) @(posedge clk24);
    #1 clkps2 = 1'b1;
    repeat (HALF) @(posedge clk24);
    #1 clkps2 = 1'b0;
    repeat (12) @(posedge clk24);
    #1 clkps2 = 1'b1;
    repeat (F - 1) @(posedge clk24);
    #1 clkps2 = 1'b0;
    repeat (HALF) @(posedge clk24);
    #1 clkps2 = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    repeat (HALF) @(posedge clk24);
  endtask

  task automatic do_ack();
    @(negedge clk24);
    ack = 1'b1;
    @(posedge clk24);
    #1 ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk24);
    @(negedge clk24);
    checks++; if (code !== 8'h00) begin failures++; $display("FAIL reset_code: got %h expected 00", code); end
    checks++; if (extended !== 1'b0) begin failures++; $display("FAIL reset_extended: got %b expected 0", extended); end
    checks++; if (released !== 1'b0) begin failures++; $display("FAIL reset_released: got %b expected 0", released); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    @(posedge clk24);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk24);
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    int e0;
    b  = 8'h1C;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b);
    dataps2 = 1'b1;
    repeat (HALF) @(posedge clk24);
    #1 clkps2 = 1'b0;
    // stop fall lands F+2 cycles after the pin edge; valid two cycles later
    repeat (F + 3) @(posedge clk24);
    @(negedge clk24);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_valid_early: got %b expected 0", valid); end
    @(negedge clk24);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL single_valid_rise: got %b expected 1", valid); end
    checks++; if (code !== 8'h1C) begin failures++; $display("FAIL single_code: got %h expected 1c", code); end
    checks++; if ({extended, released} !== 2'b00) begin failures++; $display("FAIL single_flags: got %b expected 00", {extended, released}); end
    @(posedge clk24);
    #1 clkps2 = 1'b1;
    repeat (HALF) @(posedge clk24);
    checks++; if (err_cnt != e0) begin failures++; $display("FAIL single_no_err: got %0d expected %0d", err_cnt, e0); end
    do_ack();
    @(negedge clk24);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_ack_empty: got %b expected 0", valid); end
  endtask

  task automatic test_prefix();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
`ifdef PS2_PREFIX_DECODE_EN
    @(negedge clk24);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL prefix_valid: got %b expected 1", valid); end
    checks++; if ({extended, released, code} !== 10'b11_0111_0101) begin
      failures++; $display("FAIL prefix_entry: got %b_%b_%h expected 1_1_75", extended, released, code);
    end
    do_ack();
    @(negedge clk24);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL prefix_single: got %b expected 0", valid); end
`else
    begin
      logic [7:0] exp_codes [3];
      exp_codes[0] = 8'hE0;
      exp_codes[1] = 8'hF0;
      exp_codes[2] = 8'h75;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk24);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL raw_valid[%0d]: got %b expected 1", i, valid); end
        checks++; if ({extended, released, code} !== {2'b00, exp_codes[i]}) begin
          failures++; $display("FAIL raw_entry[%0d]: got %b_%b_%h expected 0_0_%h", i, extended, released, code, exp_codes[i]);
        end
        do_ack();
      end
      @(negedge clk24);
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL raw_drained: got %b expected 0", valid); end
    end
`endif
  endtask

  task automatic test_bad_parity();
    int e0;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1);
    @(negedge clk24);
    checks++; if (err_cnt != e0 + 1) begin failures++; $display("FAIL parity_err_pulse: got %0d expected %0d", err_cnt - e0, 1); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL parity_no_entry: got %b expected 0", valid); end
    send_frame(8'h1B, 1'b0);
    @(negedge clk24);
    checks++; if (valid !== 1'b1 || code !== 8'h1B) begin failures++; $display("FAIL parity_next_good: got %b/%h expected 1/1b", valid, code); end
    checks++; if (err_cnt != e0 + 1) begin failures++; $display("FAIL parity_next_no_err: got %0d expected %0d", err_cnt - e0, 1); end
    do_ack();
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TO + 600) @(posedge clk24);
    @(negedge clk24);
    checks++; if (err_cnt != e0 + 1) begin failures++; $display("FAIL timeout_err_pulse: got %0d expected %0d", err_cnt - e0, 1); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL timeout_no_entry: got %b expected 0", valid); end
    send_frame(8'h1B, 1'b0);
    @(negedge clk24);
    checks++; if (valid !== 1'b1 || code !== 8'h1B) begin failures++; $display("FAIL timeout_recover: got %b/%h expected 1/1b", valid, code); end
    do_ack();
    @(negedge clk24);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL timeout_one_entry: got %b expected 0", valid); end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    int e0;
    b  = 8'h5A;
    e0 = err_cnt;
    send_bit_glitch(1'b0);
    for (int i = 0; i < 8; i++) send_bit_glitch(b[i]);
    send_bit_glitch(~^b);
    send_bit_glitch(1'b1);
    repeat (HALF) @(posedge clk24);
    @(negedge clk24);
    checks++; if (valid !== 1'b1 || code !== 8'h5A) begin failures++; $display("FAIL glitch_code: got %b/%h expected 1/5a", valid, code); end
    checks++; if (err_cnt != e0) begin failures++; $display("FAIL glitch_no_err: got %0d expected 0", err_cnt - e0); end
    do_ack();
    @(negedge clk24);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL glitch_one_entry: got %b expected 0", valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_codes [5];
    int o0;
    exp_codes[0] = 8'h15; exp_codes[1] = 8'h1D; exp_codes[2] = 8'h24;
    exp_codes[3] = 8'h2D; exp_codes[4] = 8'h2C;
    o0 = ovf_cnt;
    for (int i = 0; i < 5; i++) send_frame(exp_codes[i], 1'b0);
    checks++; if (ovf_cnt != o0 + 1) begin failures++; $display("FAIL overflow_pulse: got %0d expected 1", ovf_cnt - o0); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk24);
      checks++; if (valid !== 1'b1 || code !== exp_codes[i]) begin
        failures++; $display("FAIL overflow_entry[%0d]: got %b/%h expected 1/%h", i, valid, code, exp_codes[i]);
      end
      do_ack();
    end
    @(negedge clk24);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL overflow_drained: got %b expected 0", valid); end
  endtask

  task automatic test_ack_on_full_push();
    logic [7:0] exp_codes [5];
    logic [7:0] b;
    int o0;
    exp_codes[0] = 8'h16; exp_codes[1] = 8'h1E; exp_codes[2] = 8'h26;
    exp_codes[3] = 8'h25; exp_codes[4] = 8'h2E;
    o0 = ovf_cnt;
    for (int i = 0; i < 4; i++) send_frame(exp_codes[i], 1'b0);
    b = exp_codes[4];
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b);
    dataps2 = 1'b1;
    repeat (HALF) @(posedge clk24);
    #1 clkps2 = 1'b0;
    // the push happens in the cycle after the stop fall; ack during that cycle
    repeat (F + 3) @(posedge clk24);
    #1 ack = 1'b1;
    @(posedge clk24);
    #1 ack = 1'b0;
    repeat (HALF) @(posedge clk24);
    #1 clkps2 = 1'b1;
    repeat (HALF) @(posedge clk24);
    checks++; if (ovf_cnt != o0) begin failures++; $display("FAIL pushpop_no_overflow: got %0d expected 0", ovf_cnt - o0); end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk24);
      checks++; if (valid !== 1'b1 || code !== exp_codes[i]) begin
        failures++; $display("FAIL pushpop_entry[%0d]: got %b/%h expected 1/%h", i, valid, code, exp_codes[i]);
      end
      do_ack();
    end
    @(negedge clk24);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL pushpop_drained: got %b expected 0", valid); end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(posedge clk24);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk24);
    #1 rst = 1'b0;
    @(negedge clk24);
    checks++; if (valid !== 1'b0 || code !== 8'h00) begin failures++; $display("FAIL midrst_cleared: got %b/%h expected 0/00", valid, code); end
    send_frame(8'h2C, 1'b0);
    @(negedge clk24);
    checks++; if (valid !== 1'b1 || code !== 8'h2C) begin failures++; $display("FAIL midrst_next: got %b/%h expected 1/2c", valid, code); end
    checks++; if (err_cnt != e0) begin failures++; $display("FAIL midrst_no_err: got %0d expected 0", err_cnt - e0); end
    do_ack();
    @(negedge clk24);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midrst_one_entry: got %b expected 0", valid); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_prefix();
    test_bad_parity();
    test_timeout();
    test_glitch();
    test_overflow();
    test_ack_on_full_push();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
